// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrate, execute, hold result.
// Build option ALU_ARB_FIXED_PRIO_EN: req0 always wins a tie (default: round-robin).
module alu_arbiter #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned OP_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data1,
   input  logic [WIDTH-1:0] req0_data2,
   input  logic [OP_W-1:0]  req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data1,
   input  logic [WIDTH-1:0] req1_data2,
   input  logic [OP_W-1:0]  req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_is_zero,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   output logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_is_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt_q, gnt_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic [WIDTH-1:0] data2_q, data2_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             grant;
   logic             accept;

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_grant_q;
`endif
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      data1_d      = data1_q;
      data2_d      = data2_q;
      op_d         = op_q;
      result_d     = result_q;
      zero_d       = zero_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      accept       = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
            accept     = req0_valid || req1_valid;
            if (accept) begin
               gnt_d   = grant;
               data1_d = grant ? req1_data1 : req0_data1;
               data2_d = grant ? req1_data2 : req0_data2;
               op_d    = grant ? req1_op    : req0_op;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            zero_d   = alu_is_zero;
            state_d  = RESP;
         end
         RESP: begin
            rsp0_valid = !gnt_q;
            rsp1_valid = gnt_q;
            if (gnt_q ? rsp1_ready : rsp0_ready) begin
               last_grant_d = gnt_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         data1_q      <= '0;
         data2_q      <= '0;
         op_q         <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         op_q         <= op_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
      end
   end

   // Operand registers only change on accept, so the ALU inputs hold outside EXEC.
   assign alu_data1   = data1_q;
   assign alu_data2   = data2_q;
   assign alu_op      = op_q;
   assign rsp_result  = result_q;
   assign rsp_is_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a stub ALU and a transaction-level reference model.
module tb_alu_arbiter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_data1 = '0, req0_data2 = '0, req1_data1 = '0, req1_data2 = '0;
   logic [1:0]   req0_op = '0, req1_op = '0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [W-1:0] rsp_result;
   logic         rsp_is_zero;
   logic [W-1:0] alu_data1, alu_data2, alu_result;
   logic [1:0]   alu_op;
   logic         alu_is_zero;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic         pend [2];
   logic [W-1:0] pa [2];
   logic [W-1:0] pb [2];
   logic [1:0]   po [2];

   alu_arbiter #(.WIDTH(W), .OP_W(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
      .req0_data2(req0_data2), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
      .req1_data2(req1_data2), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_is_zero(rsp_is_zero),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
      .alu_result(alu_result), .alu_is_zero(alu_is_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub ALU; its isZero reflects the full-precision result, so a wrapped add is not zero.
   logic [W:0] alu_full;
   always_comb begin
      case (alu_op)
         2'b00:   alu_full = {1'b0, alu_data1} + {1'b0, alu_data2};
         2'b01:   alu_full = {1'b0, alu_data1} - {1'b0, alu_data2};
         2'b10:   alu_full = {1'b0, alu_data1 & alu_data2};
         default: alu_full = {1'b0, alu_data1 | alu_data2};
      endcase
   end
   assign alu_result  = alu_full[W-1:0];
   assign alu_is_zero = (alu_full == '0);

   function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   function automatic logic ref_zero(input logic [1:0] op, input logic [W-1:0] a, b);
      case (op)
         2'b00:   return (a == '0) && (b == '0);
         2'b01:   return a == b;
         2'b10:   return (a & b) == '0;
         default: return (a | b) == '0;
      endcase
   endfunction

   function automatic logic reqr(input int n);
      return (n == 1) ? req1_ready : req0_ready;
   endfunction

   function automatic logic rspv(input int n);
      return (n == 1) ? rsp1_valid : rsp0_valid;
   endfunction

   task automatic set_req(input int n, input logic v, input logic [W-1:0] a, b, input logic [1:0] op);
      if (n == 0) begin
         req0_valid = v; req0_data1 = a; req0_data2 = b; req0_op = op;
      end else begin
         req1_valid = v; req1_data1 = a; req1_data2 = b; req1_op = op;
      end
   endtask

   task automatic set_rsp_ready(input int n, input logic v);
      if (n == 0) rsp0_ready = v;
      else        rsp1_ready = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      set_req(0, 1'b0, '0, '0, 2'b00);
      set_req(1, 1'b0, '0, '0, 2'b00);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // Drives one request from requester n; inputs change on negedge, outputs sampled 1 time unit later.
   task automatic run_txn(input int n, input logic [W-1:0] a, b, input logic [1:0] op,
                          input int hold, input logic poke_other,
                          output int acc, output int lat, output logic [W-1:0] res,
                          output logic z, output logic [2*W+1:0] exec_alu, output logic ok);
      int rc;
      ok = 1'b1; acc = -1; lat = -1; res = '0; z = 1'b0; exec_alu = '0; rc = -1;
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req(n, 1'b1, a, b, op);
      #1;
      for (int i = 0; i < 20 && acc < 0; i++) begin
         if (reqr(n)) acc = cyc;
         else begin @(negedge clk); #1; end
      end
      if (acc < 0) begin
         ok = 1'b0;
         set_req(n, 1'b0, '0, '0, 2'b00);
         return;
      end
      @(negedge clk);
      set_req(n, 1'b0, '0, '0, 2'b00);
      if (poke_other) set_req(1 - n, 1'b1, 64'd1, 64'd1, 2'b00);
      #1;
      exec_alu = {alu_data1, alu_data2, alu_op};
      for (int i = 0; i < 10 && rc < 0; i++) begin
         if (rspv(n)) rc = cyc;
         else begin
            if (req0_ready || req1_ready || rspv(1 - n)) ok = 1'b0;
            @(negedge clk); #1;
         end
      end
      if (rc < 0) begin ok = 1'b0; return; end
      lat = rc - acc; res = rsp_result; z = rsp_is_zero;
      if (req0_ready || req1_ready || rspv(1 - n)) ok = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         if (!rspv(n) || rspv(1 - n) || rsp_result !== res || rsp_is_zero !== z ||
             req0_ready || req1_ready) ok = 1'b0;
      end
      set_rsp_ready(n, 1'b1);
      @(negedge clk);
      set_rsp_ready(n, 1'b0);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_is_zero,
           alu_data1, alu_data2, alu_op} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b%b valid=%b%b res=%h z=%b alu=%h/%h/%b, expected all 0",
                  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_is_zero,
                  alu_data1, alu_data2, alu_op);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_add();
      int acc, lat; logic [W-1:0] res; logic z, ok; logic [2*W+1:0] ex;
      run_txn(0, 64'd5, 64'd7, 2'b00, 0, 1'b0, acc, lat, res, z, ex, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_protocol: got ok=%b, expected 1", ok); end
      checks++; if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d, expected 2", lat); end
      checks++; if (ex !== {64'd5, 64'd7, 2'b00}) begin errors++; $display("FAIL add_exec_alu: got %h, expected %h", ex, {64'd5, 64'd7, 2'b00}); end
      checks++; if (res !== 64'd12) begin errors++; $display("FAIL add_result: got %h, expected %h", res, 64'd12); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_zero: got %b, expected 0", z); end
   endtask

   task automatic test_reset_mid_resp();
      logic got_resp, stray;
      got_resp = 1'b0; stray = 1'b0;
      @(negedge clk); set_req(0, 1'b1, 64'd3, 64'd4, 2'b00); #1;
      for (int i = 0; i < 10 && !req0_ready; i++) begin @(negedge clk); #1; end
      @(negedge clk); set_req(0, 1'b0, '0, '0, 2'b00); #1;
      for (int i = 0; i < 10 && !got_resp; i++) begin
         if (rsp0_valid) got_resp = 1'b1;
         else begin @(negedge clk); #1; end
      end
      checks++; if (got_resp !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got rsp0_valid=%b, expected 1", got_resp); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_is_zero,
           alu_data1, alu_data2, alu_op} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got valid=%b%b res=%h alu=%h/%h/%b, expected all 0",
                  rsp0_valid, rsp1_valid, rsp_result, alu_data1, alu_data2, alu_op);
      end
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (rsp0_valid || rsp1_valid) stray = 1'b1;
      end
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: got stray=%b, expected 0", stray); end
   endtask

   task automatic test_round_robin();
      int grants[$]; int accs[$]; int rids[$]; logic [W-1:0] rres[$];
      logic both_bad; int expg; logic [W-1:0] expr;
      both_bad = 1'b0;
      do_reset();
      @(negedge clk);
      set_req(0, 1'b1, 64'd0, 64'd1, 2'b01);
      set_req(1, 1'b1, 64'hF0, 64'h0F, 2'b11);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      for (int i = 0; i < 18; i++) begin
         if (req0_ready && req1_ready) both_bad = 1'b1;
         else if (req0_ready) begin grants.push_back(0); accs.push_back(cyc); end
         else if (req1_ready) begin grants.push_back(1); accs.push_back(cyc); end
         if (rsp0_valid) begin rids.push_back(0); rres.push_back(rsp_result); end
         if (rsp1_valid) begin rids.push_back(1); rres.push_back(rsp_result); end
         @(negedge clk); #1;
      end
      set_req(0, 1'b0, '0, '0, 2'b00);
      set_req(1, 1'b0, '0, '0, 2'b00);
      repeat (4) @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      checks++; if (both_bad !== 1'b0) begin errors++; $display("FAIL rr_double_ready: got %b, expected 0", both_bad); end
      checks++; if (grants.size() < 5) begin errors++; $display("FAIL rr_grant_count: got %0d, expected >= 5", grants.size()); end
      foreach (grants[k]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         expg = 0;
`else
         expg = k % 2;
`endif
         checks++; if (grants[k] != expg) begin errors++; $display("FAIL rr_grant[%0d]: got %0d, expected %0d", k, grants[k], expg); end
         if (k > 0) begin
            checks++; if (accs[k] - accs[k-1] != 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d, expected 3", k, accs[k] - accs[k-1]); end
         end
      end
      foreach (rids[k]) begin
         if (k < grants.size()) begin
            expr = (rids[k] == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
            checks++; if (rids[k] != grants[k]) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d, expected %0d", k, rids[k], grants[k]); end
            checks++; if (rres[k] !== expr) begin errors++; $display("FAIL rr_rsp_res[%0d]: got %h, expected %h", k, rres[k], expr); end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc, lat; logic [W-1:0] res; logic z, ok; logic [2*W+1:0] ex;
      run_txn(1, 64'hFF, 64'd0, 2'b10, 5, 1'b1, acc, lat, res, z, ex, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_stable_and_busy: got ok=%b, expected 1", ok); end
      checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency: got %0d, expected 2", lat); end
      checks++; if (res !== 64'd0) begin errors++; $display("FAIL bp_result: got %h, expected 0", res); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL bp_zero: got %b, expected 1", z); end
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got req0_ready=%b, expected 1", req0_ready); end
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, 2'b00);
      rsp0_ready = 1'b1;
      repeat (4) @(negedge clk);
      rsp0_ready = 1'b0;
   endtask

   task automatic test_exec_request();
      int acc, acc2; logic seen; logic [W-1:0] res1, res2; logic got2;
      acc = -1; acc2 = -1; seen = 1'b0; res1 = '0; res2 = '0; got2 = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 64'd10, 64'd3, 2'b01);
      rsp0_ready = 1'b1;
      #1;
      for (int i = 0; i < 10 && acc < 0; i++) begin
         if (req0_ready) acc = cyc;
         else begin @(negedge clk); #1; end
      end
      @(negedge clk); set_req(0, 1'b1, 64'd8, 64'd12, 2'b10); #1;
      for (int i = 0; i < 10 && acc2 < 0; i++) begin
         if (rsp0_valid && cyc == acc + 2) begin seen = 1'b1; res1 = rsp_result; end
         if (req0_ready) acc2 = cyc;
         else begin @(negedge clk); #1; end
      end
      checks++; if (acc < 0 || acc2 - acc != 3) begin errors++; $display("FAIL exec_req_spacing: got %0d, expected 3", acc2 - acc); end
      checks++; if (!seen || res1 !== 64'd7) begin errors++; $display("FAIL exec_req_first_res: got seen=%b res=%h, expected 1/%h", seen, res1, 64'd7); end
      @(negedge clk); set_req(0, 1'b0, '0, '0, 2'b00); #1;
      for (int i = 0; i < 10 && !got2; i++) begin
         if (rsp0_valid) begin got2 = 1'b1; res2 = rsp_result; end
         else begin @(negedge clk); #1; end
      end
      @(negedge clk); rsp0_ready = 1'b0;
      checks++; if (!got2 || res2 !== 64'd8) begin errors++; $display("FAIL exec_req_second_res: got seen=%b res=%h, expected 1/%h", got2, res2, 64'd8); end
   endtask

   task automatic test_wrap();
      int acc, lat; logic [W-1:0] res; logic z, ok; logic [2*W+1:0] ex;
      run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1, 1'b0, acc, lat, res, z, ex, ok);
      checks++; if (ok !== 1'b1 || lat != 2) begin errors++; $display("FAIL wrap_protocol: got ok=%b lat=%0d, expected 1/2", ok, lat); end
      checks++; if (res !== 64'd0) begin errors++; $display("FAIL wrap_result: got %h, expected 0", res); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL wrap_zero: got %b, expected 0", z); end
   endtask

   task automatic newreq(input int n);
      pa[n] = {$urandom, $urandom};
      pb[n] = ($urandom_range(0, 3) == 0) ? pa[n] : {$urandom, $urandom};
      po[n] = 2'($urandom_range(0, 3));
      pend[n] = 1'b1;
   endtask

   task automatic test_random();
      int lg, expw, got, w, acc, rc, hold; logic bad; logic [W-1:0] er; logic ez;
      do_reset();
      lg = 1; pend[0] = 1'b0; pend[1] = 1'b0;
      for (int it = 0; it < 40; it++) begin
         @(negedge clk);
         rsp0_ready = 1'b0; rsp1_ready = 1'b0;
         for (int n = 0; n < 2; n++) if (!pend[n] && $urandom_range(0, 1) == 1) newreq(n);
         if (!pend[0] && !pend[1]) newreq(int'($urandom_range(0, 1)));
         set_req(0, pend[0], pa[0], pb[0], po[0]);
         set_req(1, pend[1], pa[1], pb[1], po[1]);
         #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         expw = (pend[0] && pend[1]) ? 0 : (pend[1] ? 1 : 0);
`else
         expw = (pend[0] && pend[1]) ? 1 - lg : (pend[1] ? 1 : 0);
`endif
         got = -1;
         for (int i = 0; i < 5 && got < 0; i++) begin
            if (req0_ready && req1_ready) got = 2;
            else if (req0_ready) got = 0;
            else if (req1_ready) got = 1;
            else begin @(negedge clk); #1; end
         end
         checks++;
         if (got != expw) begin
            errors++;
            $display("FAIL rand_grant[%0d]: got %0d, expected %0d", it, got, expw);
            do_reset();
            lg = 1; pend[0] = 1'b0; pend[1] = 1'b0;
            continue;
         end
         w = got; acc = cyc; lg = w; bad = 1'b0; rc = -1;
         er = ref_res(po[w], pa[w], pb[w]); ez = ref_zero(po[w], pa[w], pb[w]);
         @(negedge clk); set_req(w, 1'b0, '0, '0, 2'b00); pend[w] = 1'b0; #1;
         for (int i = 0; i < 6 && rc < 0; i++) begin
            if (rspv(w)) rc = cyc;
            else begin
               if (req0_ready || req1_ready || rspv(1 - w)) bad = 1'b1;
               @(negedge clk); #1;
            end
         end
         checks++; if (rc - acc != 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, expected 2", it, rc - acc); end
         checks++;
         if (rsp_result !== er || rsp_is_zero !== ez) begin
            errors++;
            $display("FAIL rand_result[%0d]: got %h/%b, expected %h/%b (op %b)", it, rsp_result, rsp_is_zero, er, ez, po[w]);
         end
         hold = int'($urandom_range(0, 2));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if (!rspv(w) || rsp_result !== er || req0_ready || req1_ready) bad = 1'b1;
         end
         checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rand_busy_hold[%0d]: got bad=%b, expected 0", it, bad); end
         set_rsp_ready(w, 1'b1);
      end
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, 2'b00);
      set_req(1, 1'b0, '0, '0, 2'b00);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_add();
      test_reset_mid_resp();
      test_round_robin();
      test_backpressure();
      test_exec_request();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
